// File: rtl/calc_seq_ctrl_if.sv
// calc_seq_ctrl_if: beat and result handshake bundle between the sequencer, operand source, datapath and result sink
interface calc_seq_ctrl_if #(
  parameter int CNT_W = 7
);
  logic src_vld;
  logic src_rdy;
  logic [CNT_W-1:0] cnt;
  logic dp_in_vld;
  logic cap_first;
  logic cap_acc;
  logic out_vld;
  logic out_rdy;
  modport master(
    input src_vld, out_rdy,
    output src_rdy, cnt, dp_in_vld, cap_first, cap_acc, out_vld
  );
  modport slave(
    output src_vld, out_rdy,
    input src_rdy, cnt, dp_in_vld, cap_first, cap_acc, out_vld
  );
endinterface

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: beat sequencer and tile result handoff for the three-lane dot-product accumulate/compress datapath
module calc_seq_ctrl #(
  parameter int CNT_W = 7,
  parameter int LAST_CNT = 68,
  parameter int CAP0 = 35,
  parameter int CAP1 = 51,
  parameter int CAP2 = 67,
  parameter int TILE_W = 8
) (
  input logic clk,
  input logic rst,
  input logic start,
  input logic [TILE_W-1:0] num_tiles,
  input logic abort,
  output logic [TILE_W-1:0] tile_idx,
  output logic busy,
  output logic done,
  output logic start_err,
  calc_seq_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, LATCH, HOLD} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TILE_W-1:0] tile_n, ntiles, ntiles_n;
  logic done_n, err_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tile_idx <= '0;
      ntiles <= '0;
      done <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tile_idx <= tile_n;
      ntiles <= ntiles_n;
      done <= done_n;
      start_err <= err_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    tile_n = tile_idx;
    ntiles_n = ntiles;
    done_n = 1'b0;
    err_n = start & busy & ~abort;
    if (abort) begin
      state_n = IDLE;
      cnt_n = '0;
      tile_n = '0;
    end else
      case (state)
        IDLE:
          if (start) begin
            if (num_tiles != '0) begin
              state_n = RUN;
              ntiles_n = num_tiles;
              tile_n = '0;
              cnt_n = '0;
            end else
              done_n = 1'b1;
          end
        RUN:
          if (bus.src_vld) begin
            cnt_n = cnt + 1'b1;
            state_n = (cnt == CNT_W'(LAST_CNT - 1)) ? LATCH : RUN;
          end
        LATCH: begin
          cnt_n = '0;
          state_n = HOLD;
        end
        default:
          if (bus.out_rdy) begin
            if (tile_idx == ntiles - 1'b1) begin
              state_n = IDLE;
              done_n = 1'b1;
            end else begin
              tile_n = tile_idx + 1'b1;
              state_n = RUN;
            end
          end
      endcase
  end
  assign busy = state != IDLE;
  assign bus.cnt = cnt;
  assign bus.src_rdy = state == RUN;
  assign bus.out_vld = state == HOLD;
  assign bus.dp_in_vld = bus.src_vld & bus.src_rdy;
  assign bus.cap_first = bus.dp_in_vld & (cnt == CNT_W'(CAP0));
  assign bus.cap_acc = bus.dp_in_vld & ((cnt == CNT_W'(CAP1)) | (cnt == CNT_W'(CAP2)));
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: table vectors, directed multi-cycle sequences and randomized traffic against a beat-level reference model
module tb_calc_seq_ctrl;
  localparam int LAST = 68;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [7:0] num_tiles = '0;
  logic [7:0] tile_idx;
  logic busy, done, start_err;
  calc_seq_ctrl_if #(.CNT_W(7)) bus();
  calc_seq_ctrl dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .num_tiles(num_tiles),
    .abort(abort),
    .tile_idx(tile_idx),
    .busy(busy),
    .done(done),
    .start_err(start_err),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
  endtask
  bit m_busy, m_lat, m_done, m_err;
  int m_beats, m_tile, m_nt;
  int s_dp, s_capf, s_capa, s_last, s_done, s_err, s_hs, s_busy, s_wait, s_ovld_at, s_maxtile;
  task automatic mreset();
    m_busy = 0; m_lat = 0; m_done = 0; m_err = 0;
    m_beats = 0; m_tile = 0; m_nt = 0;
  endtask
  task automatic clr();
    s_dp = 0; s_capf = 0; s_capa = 0; s_last = 0; s_done = 0; s_err = 0;
    s_hs = 0; s_busy = 0; s_wait = 0; s_ovld_at = 0; s_maxtile = 0;
  endtask
  task automatic cyc();
    bit e_rdy, e_dp, e_ov;
    int e_cnt;
    @(negedge clk);
    e_rdy = m_busy && m_beats < LAST;
    e_dp = e_rdy && bus.src_vld;
    e_ov = m_busy && m_beats == LAST && !m_lat;
    e_cnt = !m_busy ? 0 : m_beats < LAST ? m_beats : m_lat ? LAST : 0;
    chk("busy", busy, m_busy);
    chk("src_rdy", bus.src_rdy, e_rdy);
    chk("cnt", bus.cnt, e_cnt);
    chk("dp_in_vld", bus.dp_in_vld, e_dp);
    chk("cap_first", bus.cap_first, e_dp && m_beats == 35);
    chk("cap_acc", bus.cap_acc, e_dp && (m_beats == 51 || m_beats == 67));
    chk("out_vld", bus.out_vld, e_ov);
    chk("done", done, m_done);
    chk("start_err", start_err, m_err);
    if (m_busy) chk("tile_idx", tile_idx, m_tile);
    if (busy) s_busy++;
    if (bus.out_vld && s_ovld_at == 0) s_ovld_at = s_busy;
    s_dp += bus.dp_in_vld;
    s_capf += bus.cap_first;
    s_capa += bus.cap_acc;
    s_last += (bus.cnt == LAST);
    s_done += done;
    s_err += start_err;
    s_hs += bus.out_vld & bus.out_rdy;
    s_wait += bus.out_vld & !bus.out_rdy;
    if (busy && tile_idx > s_maxtile) s_maxtile = tile_idx;
    m_done = 0;
    m_err = 0;
    if (abort) m_busy = 0;
    else if (!m_busy) begin
      if (start) begin
        if (num_tiles != 0) begin
          m_busy = 1; m_beats = 0; m_lat = 0; m_tile = 0; m_nt = num_tiles;
        end else m_done = 1;
      end
    end else begin
      m_err = start;
      if (m_beats < LAST) begin
        if (bus.src_vld) begin
          m_beats++;
          m_lat = m_beats == LAST;
        end
      end else if (m_lat) m_lat = 0;
      else if (bus.out_rdy) begin
        if (m_tile == m_nt - 1) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_tile++;
          m_beats = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic run_job(input int nt, input int svm, input int hold, input bit inj);
    int hc = 0;
    bit injd = 0;
    clr();
    bus.out_rdy = 0;
    bus.src_vld = 0;
    start = 1;
    num_tiles = 8'(nt);
    cyc();
    start = 0;
    for (int k = 0; k < 30000 && s_done == 0; k++) begin
      bus.src_vld = svm == 0 ? 1'b1 : svm == 1 ? (k % 2 == 0) : ($urandom_range(3) != 0);
      if (bus.out_vld) hc++;
      bus.out_rdy = hc > hold;
      start = inj && !injd && busy && bus.cnt == 20 && bus.src_rdy;
      if (start) injd = 1;
      cyc();
    end
    start = 0;
    chk("job_done", s_done, 1);
  endtask
  typedef struct {
    int start, nt, ab, sv;
    int busy, cnt, dp, done, err;
  } vec_t;
  vec_t tv[10];
  initial begin
    tv[0] = '{1, 0, 0, 0, 0, 0, 0, 1, 0};
    tv[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tv[2] = '{1, 2, 0, 0, 1, 0, 0, 0, 0};
    tv[3] = '{1, 2, 0, 1, 1, 1, 1, 0, 1};
    tv[4] = '{0, 2, 0, 0, 1, 1, 0, 0, 0};
    tv[5] = '{1, 2, 1, 1, 0, 0, 0, 0, 0};
    tv[6] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    tv[7] = '{1, 1, 0, 1, 1, 0, 1, 0, 0};
    tv[8] = '{0, 1, 0, 1, 1, 1, 1, 0, 0};
    tv[9] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    bus.src_vld = 0;
    bus.out_rdy = 0;
    mreset();
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_src_rdy", bus.src_rdy, 0);
    chk("rst_out_vld", bus.out_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_err", start_err, 0);
    chk("rst_tile", tile_idx, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      start = tv[i].start[0];
      num_tiles = 8'(tv[i].nt);
      abort = tv[i].ab[0];
      bus.src_vld = tv[i].sv[0];
      @(posedge clk);
      #2;
      chk($sformatf("tv%0d_busy", i), busy, tv[i].busy);
      chk($sformatf("tv%0d_cnt", i), bus.cnt, tv[i].cnt);
      chk($sformatf("tv%0d_dp", i), bus.dp_in_vld, tv[i].dp);
      chk($sformatf("tv%0d_done", i), done, tv[i].done);
      chk($sformatf("tv%0d_err", i), start_err, tv[i].err);
    end
    start = 0;
    abort = 0;
    bus.src_vld = 0;
    @(posedge clk);
    #1;
    mreset();
    run_job(1, 0, 0, 0);
    chk("t1_beats", s_dp, 68);
    chk("t1_cap_first", s_capf, 1);
    chk("t1_cap_acc", s_capa, 2);
    chk("t1_last_cycles", s_last, 1);
    chk("t1_out_vld_cycle", s_ovld_at, 70);
    chk("t1_handshakes", s_hs, 1);
    run_job(3, 1, 0, 0);
    chk("t2_beats", s_dp, 204);
    chk("t2_handshakes", s_hs, 3);
    chk("t2_max_tile", s_maxtile, 2);
    chk("t2_last_cycles", s_last, 3);
    run_job(2, 0, 10, 0);
    chk("t3_wait_cycles", s_wait, 10);
    chk("t3_handshakes", s_hs, 2);
    run_job(0, 0, 0, 0);
    chk("t4_busy_cycles", s_busy, 0);
    run_job(2, 0, 0, 1);
    chk("t4_start_err", s_err, 1);
    chk("t4_beats", s_dp, 136);
    clr();
    start = 1;
    num_tiles = 4;
    bus.src_vld = 1;
    bus.out_rdy = 1;
    cyc();
    start = 0;
    for (int k = 0; k < 500 && !(tile_idx == 1 && bus.cnt == 50 && bus.src_rdy); k++) cyc();
    chk("abort_reached", int'(tile_idx == 1 && bus.cnt == 50), 1);
    abort = 1;
    cyc();
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_cnt", bus.cnt, 0);
    chk("abort_out_vld", bus.out_vld, 0);
    repeat (5) cyc();
    chk("abort_no_done", s_done, 0);
    run_job(1, 0, 0, 0);
    chk("post_abort_beats", s_dp, 68);
    start = 1;
    num_tiles = 2;
    bus.src_vld = 1;
    bus.out_rdy = 1;
    cyc();
    start = 0;
    for (int k = 0; k < 200 && bus.cnt != 40; k++) cyc();
    chk("rst_mid_reached", bus.cnt, 40);
    #2 rst = 1;
    #1;
    chk("rst_mid_cnt", bus.cnt, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_src_rdy", bus.src_rdy, 0);
    chk("rst_mid_dp", bus.dp_in_vld, 0);
    chk("rst_mid_out_vld", bus.out_vld, 0);
    chk("rst_mid_tile", tile_idx, 0);
    chk("rst_mid_done", done, 0);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    mreset();
    run_job(1, 0, 0, 0);
    chk("post_rst_beats", s_dp, 68);
    chk("post_rst_out_vld_cycle", s_ovld_at, 70);
    run_job(3, 2, 0, 0);
    chk("rnd_job_beats", s_dp, 204);
    run_job(255, 0, 0, 0);
    chk("t255_handshakes", s_hs, 255);
    chk("t255_max_tile", s_maxtile, 254);
    for (int k = 0; k < 4000; k++) begin
      start = $urandom_range(19) == 0;
      num_tiles = 8'($urandom_range(3));
      abort = $urandom_range(199) == 0;
      bus.src_vld = $urandom_range(3) != 0;
      bus.out_rdy = $urandom_range(1) != 0;
      cyc();
    end
    start = 0;
    abort = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
- Sequencer for the three-lane dot-product accumulate/compress datapath in the calc block.
- Drives the datapath's beat counter `cnt` and its `in_vld`.
- Decodes the capture beats (first load, accumulate) and the compress-latch beat.
- Runs a programmable number of tiles back to back and hands each compressed 8-bit result downstream over a valid/ready handshake.

Parameters:
- CNT_W, 7, width of the beat counter driven to the datapath.
- LAST_CNT, 68, beat on which the datapath latches the compressed result.
- CAP0, 35, beat on which the lane results are loaded (first partial).
- CAP1, 51, first accumulate beat.
- CAP2, 67, second accumulate beat.
- TILE_W, 8, width of the tile count and tile index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a job; honoured only in IDLE.
- num_tiles  in  TILE_W  tiles in the job; sampled on an accepted start.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- src_vld  in  1  upstream operand data valid for the current beat.
- src_rdy  out  1  controller will consume a beat (1 only in RUN).
- cnt  out  CNT_W  beat counter to the datapath.
- dp_in_vld  out  1  datapath in_vld; equals src_vld & src_rdy.
- cap_first  out  1  dp_in_vld & (cnt==CAP0); monitor/debug.
- cap_acc  out  1  dp_in_vld & (cnt==CAP1 | cnt==CAP2); monitor/debug.
- out_vld  out  1  compressed result on the datapath's ans_reg is valid.
- out_rdy  in  1  downstream accepts the result.
- tile_idx  out  TILE_W  index of the tile in progress.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the last tile's result is accepted.
- start_err  out  1  one-cycle pulse when start arrives while busy; that start is ignored.

Behaviour:
- Reset values (rst high, asynchronous): state=IDLE; cnt, tile_idx, latched num_tiles = 0; all 1-bit outputs 0.
- States are IDLE, RUN, LATCH and HOLD. All outputs are registered or decoded from registered state, cnt and src_vld; there is no combinational path from out_rdy.
- IDLE
  - start with num_tiles != 0: latch num_tiles, tile_idx=0, cnt=0, go to RUN.
  - start with num_tiles == 0: pulse done the next cycle, stay in IDLE.
- RUN
  - src_rdy=1.
  - On src_vld, cnt increments by 1. With no src_vld, cnt holds (stall, no beat).
  - When src_vld and cnt==LAST_CNT-1: cnt becomes LAST_CNT and state goes to LATCH.
- LATCH (exactly 1 cycle)
  - cnt==LAST_CNT, src_rdy=0, dp_in_vld=0; the datapath latches compress on this edge.
  - Next: cnt=0, state=HOLD.
- HOLD
  - out_vld=1, cnt=0, src_rdy=0. out_vld stays high until out_rdy.
  - On out_vld & out_rdy with tile_idx == num_tiles-1: go to IDLE and pulse done in the same transition cycle (done is high the cycle after the handshake).
  - On out_vld & out_rdy otherwise: tile_idx+1, go to RUN.
- Latency: minimum tile time is LAST_CNT+2 cycles from RUN entry to out_vld (68 beats, 1 LATCH cycle, then HOLD). Each stall cycle adds 1.
- Beats 0..LAST_CNT-1 each consume exactly one src_vld handshake; a tile consumes exactly LAST_CNT beats.
- cnt never exceeds LAST_CNT, and holds LAST_CNT for exactly one cycle per tile.
- abort (priority below rst, above all else): next state IDLE, cnt=0, tile_idx=0, out_vld=0; no done.
- start together with abort: abort wins, start is ignored, no start_err.
- start while busy: ignored; start_err pulses the next cycle.
- tile_idx wraps are impossible because num_tiles is at most 2^TILE_W-1; num_tiles=255 runs 255 tiles.
- rst asserted mid-tile: immediate return to reset values. The datapath's partial sums are stale but harmless, because the next tile reloads on CAP0.

Test Plan:
- Reset; start with num_tiles=1; src_vld=1 constant; out_rdy=1 → cap_first at cnt=35, cap_acc at 51 and 67, cnt=68 for one cycle, out_vld at cycle 70 after RUN entry, done the next cycle; 68 dp_in_vld pulses total.
- num_tiles=3; src_vld toggling 1,0,1,0... → each cnt value held 2 cycles, no beat skipped or duplicated; tile_idx steps 0→1→2; done once after the 3rd handshake.
- num_tiles=2; out_rdy held low 10 cycles in HOLD → out_vld stays 1, cnt=0, src_rdy=0 throughout; RUN resumes the cycle after out_rdy=1.
- start with num_tiles=0 → done pulse and busy never 1; start in RUN at cnt=20 → start_err pulse and the sequence is unaffected.
- abort at cnt=50 in tile 1 of 4 → IDLE next cycle, cnt=0, no done; a following start (num_tiles=1) completes normally.
- rst pulse at cnt=40, asynchronous mid-cycle → all outputs 0 immediately; a start after deassertion gives a normal 68-beat run.
